// File: rtl/mmm_pkg.sv
// ============================================================================
//  Module   : mmm_pkg
//  Purpose  : Shared instruction-cache types and line geometry constants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmm_pkg;

    localparam int ICACHE_BEATS  = 4;
    localparam int ICACHE_LINE_W = 32 * ICACHE_BEATS;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_REFILL   = 3'd3,
        S_RESPOND  = 3'd4
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_refill_buf.sv
// ============================================================================
//  Module   : icache_refill_buf
//  Purpose  : Assembles 32-bit refill beats into one cache line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_buf
    import mmm_pkg::*;
#(
    parameter int BEATS = ICACHE_BEATS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  en_i,
    input  logic                  beat_valid_i,
    input  logic [31:0]           beat_data_i,
    output logic [32*BEATS-1:0]   line_o,
    output logic [32*BEATS-1:0]   line_next_o,
    output logic                  last_o
);

    localparam int c_cnt_w  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_line_w = 32 * BEATS;

    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_line_w-1:0] r_line;
    logic                w_take;

    assign w_take = en_i && beat_valid_i;
    assign last_o = w_take && (r_cnt == c_cnt_w'(BEATS - 1));
    assign line_o = r_line;

    // Beats shift in from the top so beat k ends up at bits [32k+31:32k].
    generate
        if (BEATS > 1) begin : g_shift
            assign line_next_o = {beat_data_i, r_line[c_line_w-1:32]};
        end else begin : g_single
            assign line_next_o = beat_data_i;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (start_i) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_line <= line_next_o;
            r_cnt  <= last_o ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_ctrl.sv
// ============================================================================
//  Module   : icache_ctrl
//  Purpose  : Direct-mapped instruction cache controller with line refill.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl
    import mmm_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int BEATS     = ICACHE_BEATS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                invalidate_i,
    input  logic                read_req_i,
    input  logic [31:0]         read_addr_i,
    output logic                read_done_o,
    output logic [32*BEATS-1:0] read_line_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_resp_valid_i,
    input  logic [31:0]         mem_resp_data_i
);

    localparam int c_idx_w  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int c_tag_w  = 32 - 4 - c_idx_w;
    localparam int c_line_w = 32 * BEATS;

    icache_state_t       r_state;
    logic [31:0]         r_addr;
    logic [31:0]         r_pend_addr;
    logic                r_pend;
    logic                r_squash;
    logic [NUM_LINES-1:0] r_valid;
    logic [c_tag_w-1:0]  r_tag_arr  [NUM_LINES];
    logic [c_line_w-1:0] r_data_arr [NUM_LINES];

    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic                w_hit;
    logic                w_last;
    logic                w_wr;
    logic                w_squashed;
    logic                w_buf_take;
    logic [c_line_w-1:0] w_buf_line;
    logic [c_line_w-1:0] w_buf_next;
    logic                w_unused_bits;

    assign w_idx         = r_addr[4 +: c_idx_w];
    assign w_tag         = r_addr[31 -: c_tag_w];
    assign w_hit         = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_wr          = (r_state == S_REFILL) && w_last;
    assign w_squashed    = r_squash || flush_i;
    assign w_buf_take    = (r_state == S_REFILL) && r_squash && read_req_i && !flush_i;
    assign w_unused_bits = ^{r_addr[3:0], r_pend_addr[3:0]};

    icache_refill_buf #(.BEATS(BEATS)) u_refill_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (r_state == S_MISS_REQ),
        .en_i         (r_state == S_REFILL),
        .beat_valid_i (mem_resp_valid_i),
        .beat_data_i  (mem_resp_data_i),
        .line_o       (w_buf_line),
        .line_next_o  (w_buf_next),
        .last_o       (w_last)
    );

    assign read_done_o     = !flush_i && (((r_state == S_LOOKUP) && w_hit) || (r_state == S_RESPOND));
    assign read_line_o     = !read_done_o ? '0 :
                             (r_state == S_LOOKUP) ? r_data_arr[w_idx] : w_buf_line;
    assign mem_req_valid_o = (r_state == S_MISS_REQ);
    assign mem_addr_o      = mem_req_valid_o ? {r_addr[31:4], 4'b0000} : 32'd0;

    // Tag and data storage carry no reset; only the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_tag_arr[w_idx]  <= w_tag;
            r_data_arr[w_idx] <= w_buf_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pend_addr <= '0;
            r_pend      <= 1'b0;
            r_squash    <= 1'b0;
            r_valid     <= '0;
        end else begin
            if (invalidate_i) begin
                r_valid <= '0;
            end else if (w_wr) begin
                r_valid[w_idx] <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!flush_i && read_req_i) begin
                        r_addr  <= read_addr_i;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP, S_RESPOND: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_state == S_LOOKUP && !w_hit) begin
                        r_state <= S_MISS_REQ;
                    end else if (read_req_i) begin
                        r_addr  <= read_addr_i;
                        r_state <= S_LOOKUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_req_ready_i) begin
                        r_squash <= flush_i;
                        r_state  <= S_REFILL;
                    end else if (flush_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    if (flush_i) r_squash <= 1'b1;
                    if (w_buf_take) begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= read_addr_i;
                    end
                    // A squashed refill still lands in the array but resumes at the buffered request.
                    if (w_last) begin
                        r_squash <= 1'b0;
                        r_pend   <= 1'b0;
                        if (!w_squashed) begin
                            r_state <= S_RESPOND;
                        end else if (w_buf_take) begin
                            r_addr  <= read_addr_i;
                            r_state <= S_LOOKUP;
                        end else if (r_pend) begin
                            r_addr  <= r_pend_addr;
                            r_state <= S_LOOKUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
//  Module   : tb_icache_ctrl
//  Purpose  : Directed self-checking bench for icache_ctrl with a line scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_icache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         flush_i = 1'b0;
    logic         invalidate_i = 1'b0;
    logic         read_req_i = 1'b0;
    logic [31:0]  read_addr_i = 32'd0;
    logic         read_done_o;
    logic [127:0] read_line_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [31:0]  mem_addr_o;
    logic         mem_resp_valid_i = 1'b0;
    logic [31:0]  mem_resp_data_i = 32'd0;

    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;
    int           done_mark;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;

    always #5 clk_i = ~clk_i;

    icache_ctrl #(.NUM_LINES(16), .BEATS(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .invalidate_i     (invalidate_i),
        .read_req_i       (read_req_i),
        .read_addr_i      (read_addr_i),
        .read_done_o      (read_done_o),
        .read_line_o      (read_line_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // Scoreboard: every read_done_o pulse must match the oldest expected line.
    always @(negedge clk_i) begin
        if (!rst_i && read_done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {127'd0, read_done_o}, 128'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("line", read_line_o, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input logic [31:0] addr);
        read_req_i  = 1'b1;
        read_addr_i = addr;
        tick();
        read_req_i  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = d;
        tick();
        mem_resp_valid_i = 1'b0;
    endtask

    task automatic wait_mem(input logic [31:0] exp_addr);
        int n = 0;
        @(negedge clk_i);
        while (!mem_req_valid_o && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        check("mem_valid", mem_req_valid_o, 1);
        check("mem_addr", mem_addr_o, exp_addr);
        tick();
        @(negedge clk_i);
        check("mem_hold", mem_addr_o, exp_addr);
        tick();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk_i);
        while (!read_done_o && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        check("done_seen", read_done_o, 1);
        tick();
    endtask

    // Full miss: request, memory handshake, four beats with an idle gap, response.
    task automatic fill(input logic [31:0] addr, input logic [31:0] base);
        exp_q.push_back(mkline(base));
        do_req(addr);
        wait_mem({addr[31:4], 4'b0000});
        beat(base);
        mem_resp_data_i = 32'hDEAD_BEEF;
        tick();
        beat(base + 32'd1);
        beat(base + 32'd2);
        beat(base + 32'd3);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_done", read_done_o, 0);
        check("rst_line", read_line_o, 0);
        check("rst_memv", mem_req_valid_o, 0);
        check("rst_addr", mem_addr_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        // Cold miss then hit with one-cycle latency.
        fill(32'h0000_1004, 32'h0000_00A0);
        exp_q.push_back(128'h000000A3_000000A2_000000A1_000000A0);
        do_req(32'h0000_1004);
        @(negedge clk_i);
        check("hit_lat", read_done_o, 1);
        check("hit_nomem", mem_req_valid_o, 0);
        tick();

        // Back-to-back hits.
        exp_q.push_back(mkline(32'hA0));
        exp_q.push_back(mkline(32'hA0));
        read_req_i  = 1'b1;
        read_addr_i = 32'h0000_1000;
        tick();
        read_addr_i = 32'h0000_1008;
        @(negedge clk_i);
        check("b2b_1", read_done_o, 1);
        tick();
        read_req_i = 1'b0;
        @(negedge clk_i);
        check("b2b_2", read_done_o, 1);
        tick();

        // Flush after beat 1, request 0x2000 buffered during the squashed refill.
        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        done_mark = done_cnt;
        do_req(32'h0000_1000);
        wait_mem(32'h0000_1000);
        beat(32'hB0);
        beat(32'hB1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        do_req(32'h0000_2000);
        beat(32'hB2);
        beat(32'hB3);
        exp_q.push_back(mkline(32'hC0));
        wait_mem(32'h0000_2000);
        beat(32'hC0);
        beat(32'hC1);
        beat(32'hC2);
        beat(32'hC3);
        wait_done();
        check("flush_dones", done_cnt - done_mark, 1);

        // Squashed refill without a pending request still writes the array.
        do_req(32'h0000_1040);
        wait_mem(32'h0000_1040);
        beat(32'hD0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        beat(32'hD1);
        beat(32'hD2);
        beat(32'hD3);
        tick();
        @(negedge clk_i);
        check("sq_idle", mem_req_valid_o, 0);
        tick();
        exp_q.push_back(mkline(32'hD0));
        do_req(32'h0000_1040);
        @(negedge clk_i);
        check("sq_written", read_done_o, 1);
        tick();

        // Flush on a hit cycle suppresses the response.
        do_req(32'h0000_1040);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_sup", read_done_o, 0);
        tick();
        flush_i = 1'b0;

        // Conflict eviction on index 0, then invalidate.
        fill(32'h0000_1000, 32'h10);
        fill(32'h0000_1100, 32'h20);
        do_req(32'h0000_1000);
        @(negedge clk_i);
        check("conf_miss", read_done_o, 0);
        tick();
        exp_q.push_back(mkline(32'h30));
        wait_mem(32'h0000_1000);
        beat(32'h30);
        beat(32'h31);
        beat(32'h32);
        beat(32'h33);
        wait_done();
        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        do_req(32'h0000_1000);
        @(negedge clk_i);
        check("inv_miss", read_done_o, 0);
        tick();
        exp_q.push_back(mkline(32'h40));
        wait_mem(32'h0000_1000);
        beat(32'h40);
        beat(32'h41);
        beat(32'h42);
        beat(32'h43);
        wait_done();

        // Reset mid-refill abandons it; later beats are ignored.
        do_req(32'h0000_3000);
        wait_mem(32'h0000_3000);
        beat(32'hE0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        beat(32'hE1);
        beat(32'hE2);
        beat(32'hE3);
        @(negedge clk_i);
        check("rst_mid_memv", mem_req_valid_o, 0);
        check("rst_mid_done", read_done_o, 0);
        tick();
        fill(32'h0000_3000, 32'hF0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter BEATS, default 4, number of 32-bit memory beats per line; line width = 32*BEATS = 128.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk_i (in, 1, rising-edge clock) and rst_i (in, 1, async active-high reset).
REQ-004 flush_i  in  1  abort current fetch request.
REQ-005 invalidate_i  in  1  clear all valid bits.
REQ-006 read_req_i  in  1  single-cycle fetch read request pulse.
REQ-007 read_addr_i  in  32  byte address of request.
REQ-008 read_done_o  out  1  single-cycle pulse; line valid.
REQ-009 read_line_o  out  128  returned line; 0 when read_done_o=0.
REQ-010 mem_req_valid_o  out  1  refill request to memory.
REQ-011 mem_req_ready_i  in  1  memory accepts request.
REQ-012 mem_addr_o  out  32  line-aligned refill address; 0 when mem_req_valid_o=0.
REQ-013 mem_resp_valid_i  in  1  refill beat valid.
REQ-014 mem_resp_data_i  in  32  refill beat data.

Function
REQ-015 Address split SHALL be offset [3:0], index [3+log2(NUM_LINES):4], tag = remaining upper bits.
REQ-016 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
REQ-017 IDLE: read_req_i=1 SHALL latch read_addr_i, next LOOKUP; else stay.
REQ-018 LOOKUP hit (valid & tag match): read_done_o=1, read_line_o=stored line, same cycle; hit latency = 1 cycle after request.
REQ-019 LOOKUP miss: no output, next MISS_REQ.
REQ-020 MISS_REQ: mem_req_valid_o=1, mem_addr_o={addr[31:4],4'b0} held stable until mem_req_ready_i=1, then next REFILL with beat counter=0.
REQ-021 REFILL: each mem_resp_valid_i=1 SHALL write beat k to line bits [32k+31:32k] and increment counter; beats with valid=0 are ignored.
REQ-022 On beat BEATS-1 SHALL write data, tag and valid=1 to the indexed entry at that edge, next RESPOND.
REQ-023 RESPOND: read_done_o=1, read_line_o=assembled line, next IDLE.
REQ-024 A read_req_i coinciding with read_done_o=1 (LOOKUP hit or RESPOND) SHALL be accepted: latch address, next LOOKUP (back-to-back hits, one per cycle).
REQ-025 read_req_i in MISS_REQ or unsquashed REFILL SHALL be ignored (protocol violation).
REQ-026 flush_i has priority over read_req_i; a request in the flush cycle SHALL be dropped.
REQ-027 flush_i in IDLE/LOOKUP/RESPOND: suppress read_done_o that cycle, next IDLE.
REQ-028 flush_i in MISS_REQ with mem_req_ready_i=0: deassert request, next IDLE; with mem_req_ready_i=1: handshake counts, next REFILL squashed.
REQ-029 flush_i in REFILL: set squash flag; refill SHALL complete and write the array, but no RESPOND, no read_done_o.
REQ-030 During squashed refill one read_req_i SHALL be buffered (later requests overwrite it); at refill end go LOOKUP with buffered address if present, else IDLE.
REQ-031 invalidate_i SHALL clear all valid bits at the next edge; coinciding refill write SHALL leave that entry invalid; an in-flight LOOKUP in that cycle uses pre-clear contents.

Reset
REQ-032 rst_i SHALL force state IDLE, all valid bits 0, squash flag 0, pending buffer empty, beat counter 0, all outputs 0; tag/data arrays not reset.
REQ-033 rst_i mid-refill SHALL abandon the refill; remaining memory beats after reset are ignored in IDLE.

Structure
REQ-034 icache_state_t enum, ICACHE_LINE_W, ICACHE_BEATS constants SHALL live in mmm_pkg.
REQ-035 Beat assembly (counter, shift-in buffer, last-beat flag) SHALL be sub-module icache_refill_buf.

Verification
REQ-036 Cold miss: req 0x0000_1004 -> mem_addr_o=0x0000_1000; beats 0xA0,0xA1,0xA2,0xA3 -> read_done_o with line 0x000000A3_000000A2_000000A1_000000A0.
REQ-037 Hit: same req again -> read_done_o next cycle, same line, no mem_req_valid_o.
REQ-038 Back-to-back: req 0x1000 then req 0x1008 on read_done cycle -> two consecutive read_done_o pulses.
REQ-039 Flush mid-refill after beat 1, req 0x2000 next cycle -> no read_done for old; 0x1000 line written; then 0x2000 serviced via LOOKUP.
REQ-040 Conflict + invalidate: fill 0x1000, fill 0x1100 (same index 0) -> 0x1000 misses; invalidate_i then req 0x1100 -> miss.
